// File: rtl/mul_div_pkg.sv
// Shared definitions for the sequential multiply/divide family:
// FSM state encoding, default operand width and product type.
package mul_div_pkg;

  localparam int MUL_DIV_WIDTH = 4;

  // Encoding 2'd3 is unused; the FSMs recover from it to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_div_state_e;

  typedef logic [2*MUL_DIV_WIDTH-1:0] mul_div_prod_t;

endpackage

// File: rtl/shift_add_step.sv
// One radix-2 shift-add iteration: conditionally add the multiplicand into the
// accumulator, then shift the multiplicand left and the multiplier right.
module shift_add_step
  import mul_div_pkg::*;
#(
  parameter int WIDTH = MUL_DIV_WIDTH
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [2*WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0]   i_mplier,
  output logic [2*WIDTH-1:0] o_acc,
  output logic [2*WIDTH-1:0] o_mcand,
  output logic [WIDTH-1:0]   o_mplier
);

  // Accumulate when the current multiplier LSB is set; the sum fits in 2*WIDTH bits.
  always_comb begin
    o_acc    = i_acc;
    o_mcand  = i_mcand << 1;
    o_mplier = i_mplier >> 1;
    if (i_mplier[0]) begin
      o_acc = i_acc + i_mcand;
    end else begin
      o_acc = i_acc;
    end
  end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Start-driven unsigned shift-add multiplier: one multiplier bit per clock,
// product and a one-cycle done pulse WIDTH+1 edges after the start is accepted.
module seq_shift_add_multiplier
  import mul_div_pkg::*;
#(
  parameter int WIDTH = MUL_DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mul_div_state_e     r_state;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_product;
  logic               r_done;

  logic [2*WIDTH-1:0] w_acc;
  logic [2*WIDTH-1:0] w_mcand;
  logic [WIDTH-1:0]   w_mplier;

  shift_add_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_acc    (r_acc),
    .i_mcand  (r_mcand),
    .i_mplier (r_mplier),
    .o_acc    (w_acc),
    .o_mcand  (w_mcand),
    .o_mplier (w_mplier)
  );

  // Control FSM, iteration counter and registered product/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, multiplicand};
            r_mplier <= multiplier;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= ST_RUN;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        // Always exactly WIDTH iterations, even for a zero multiplier.
        ST_RUN: begin
          r_done   <= 1'b0;
          r_acc    <= w_acc;
          r_mcand  <= w_mcand;
          r_mplier <= w_mplier;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_DONE: begin
          r_product <= r_acc;
          r_done    <= 1'b1;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign product = r_product;
  assign done    = r_done;

endmodule
